// File: rtl/cdc_handshake_tx.sv
// cdc_handshake_tx: source side of a four-phase req/ack bundled-data crossing.
// Optional macro CDC_TX_TIMEOUT_EN adds an abort when ack never rises.
module cdc_handshake_tx #(
    parameter int DATA_WIDTH     = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  send,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err,
    output logic                  req_out,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  ack_async
);
    typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;
    state_t state, state_nx;
    logic [SYNC_STAGES-1:0] ack_ff;
    logic ack_sync, req_nx, done_nx, ld, expired, aborted;

    if (SYNC_STAGES < 2 || SYNC_STAGES > 3 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("cdc_handshake_tx: illegal parameter value");
    end

    assign ack_sync = ack_ff[SYNC_STAGES-1];
    assign ready    = (state == IDLE) && !ack_sync;
    assign busy     = (state != IDLE);

    always_comb begin
        state_nx = state;
        req_nx   = req_out;
        done_nx  = 1'b0;
        ld       = 1'b0;
        case (state)
            IDLE: if (send && ready) begin
                ld       = 1'b1;
                req_nx   = 1'b1;
                state_nx = REQ;
            end
            REQ: if (ack_sync || expired) begin
                req_nx   = 1'b0;
                state_nx = RELEASE;
            end
            RELEASE: if (!ack_sync) begin
                state_nx = IDLE;
                done_nx  = !aborted;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ack_ff   <= '0;
            req_out  <= 1'b0;
            done     <= 1'b0;
            data_out <= '0;
        end else begin
            state    <= state_nx;
            ack_ff   <= {ack_ff[SYNC_STAGES-2:0], ack_async};
            req_out  <= req_nx;
            done     <= done_nx;
            if (ld) data_out <= data_in;
        end
    end

`ifdef CDC_TX_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CW-1:0] cnt;
    // A normal ack wins over expiry when both land on the same cycle.
    assign expired = (state == REQ) && !ack_sync && (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            aborted     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            cnt         <= (state == REQ) ? cnt + CW'(!ack_sync) : '0;
            aborted     <= expired || (aborted && !ld);
            timeout_err <= expired;
        end
    end
`else
    assign expired     = 1'b0;
    assign aborted     = 1'b0;
    assign timeout_err = 1'b0;
`endif
endmodule
